// File: rtl/parser_rule_cfg_arbiter.sv
// Round-robin arbiter that funnels host/CPU rule-configuration accesses into the
// per-layer rule ports of the parser chain, one request in flight at a time.
module parser_rule_cfg_arbiter #(
  parameter int LAYER_NUM = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  input  logic [1:0]                 i_req_wr,
  input  logic [1:0][31:0]           i_req_addr,
  input  logic [1:0][31:0]           i_req_wdata,
  output logic [1:0]                 o_resp_valid,
  output logic [31:0]                o_resp_rdata,
  output logic                       o_resp_err,
  output logic [LAYER_NUM-1:0]       o_rule_wren,
  output logic [LAYER_NUM-1:0]       o_rule_rden,
  output logic [31:0]                o_rule_addr,
  output logic [31:0]                o_rule_wdata,
  input  logic [LAYER_NUM-1:0]       i_rule_rdata_valid,
  input  logic [LAYER_NUM-1:0][31:0] i_rule_rdata,
  output logic                       o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   rr_q, rr_d;
  logic                   g_q, g_d;
  logic                   wr_q, wr_d;
  logic [3:0]             layer_q, layer_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [LAYER_NUM-1:0]   wren_q, wren_d, rden_q, rden_d;
  logic [31:0]            addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [1:0]             resp_q, resp_d;
  logic                   busy_q;

  logic                   gnt_any, gnt_idx, in_range;
  logic [3:0]             req_layer;
  logic [LAYER_NUM-1:0]   layer_hit;
  logic [15:0]            vld_pad;
  logic [15:0][31:0]      dat_pad;
  logic                   tgt_vld;
  logic [31:0]            tgt_dat;

  // Preferred requester wins if valid; reset blocks any handshake.
  assign gnt_any   = (|i_req_valid) && !i_rst;
  assign gnt_idx   = i_req_valid[rr_q] ? rr_q : ~rr_q;
  assign req_layer = i_req_addr[gnt_idx][31:28];
  assign in_range  = int'({28'b0, req_layer}) < LAYER_NUM;

  // Pad the per-layer read return to 16 entries so any 4-bit layer index is legal.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pad
      if (gi < LAYER_NUM) begin : g_real
        assign vld_pad[gi] = i_rule_rdata_valid[gi];
        assign dat_pad[gi] = i_rule_rdata[gi];
      end else begin : g_zero
        assign vld_pad[gi] = 1'b0;
        assign dat_pad[gi] = 32'b0;
      end
    end
    for (gi = 0; gi < LAYER_NUM; gi++) begin : g_hit
      assign layer_hit[gi] = (req_layer == 4'(gi));
    end
  endgenerate

  assign tgt_vld = vld_pad[layer_q];
  assign tgt_dat = dat_pad[layer_q];

  assign o_req_ready = (state_q == IDLE && gnt_any) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    wr_d    = wr_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = '0;
    rden_d  = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    resp_d  = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          g_d     = gnt_idx;
          wr_d    = i_req_wr[gnt_idx];
          layer_d = req_layer;
          addr_d  = {4'b0, i_req_addr[gnt_idx][27:0]};
          wdata_d = i_req_wdata[gnt_idx];
          if (!in_range) begin
            state_d         = RESP;
            err_d           = 1'b1;
            resp_d[gnt_idx] = 1'b1;
          end else begin
            state_d = ISSUE;
            if (i_req_wr[gnt_idx]) wren_d = layer_hit;
            else                   rden_d = layer_hit;
          end
        end
      end
      ISSUE: begin
        // Layers may answer combinationally in the strobe cycle.
        if (wr_q) begin
          state_d     = RESP;
          resp_d[g_q] = 1'b1;
        end else if (tgt_vld) begin
          state_d     = RESP;
          rdata_d     = tgt_dat;
          resp_d[g_q] = 1'b1;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = 8'd0;
        end
      end
      WAIT_RD: begin
        if (tgt_vld) begin
          state_d     = RESP;
          rdata_d     = tgt_dat;
          resp_d[g_q] = 1'b1;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = RESP;
          err_d       = 1'b1;
          resp_d[g_q] = 1'b1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      RESP: begin
        rr_d    = ~g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      wr_q    <= 1'b0;
      layer_q <= 4'd0;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= '0;
      rden_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      wr_q    <= wr_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_resp_valid = resp_q;
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;
  assign o_rule_wren  = wren_q;
  assign o_rule_rden  = rden_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_busy       = busy_q;

endmodule

// File: doc/parser_rule_cfg_arbiter.md
# parser_rule_cfg_arbiter

Sequences rule-configuration accesses into the pipelined parser. Two requesters (host configuration port and on-chip management CPU) share one rule-configuration path. The block arbitrates between them round-robin, decodes the target parser layer from the address, and issues exactly one write or read strobe to that layer. It then returns a single response per request, with a timeout for reads that never complete. It sits between the configuration masters and the per-layer rule ports (`rule_wren/rden/addr/wdata/rdata_valid/rdata`) of the parser layer chain.

## Interface
- `LAYER_NUM`, 4: number of parser layers (1..16).
- `TIMEOUT`, 15: cycles to wait for a read response before erroring (1..255).
- `i_clk` in 1: clock. Single clock domain; reset is synchronous and active-high.
- `i_rst` in 1: reset (synchronous, active-high).
- `i_req_valid` in 2: per-requester request valid. Index 0 = host, 1 = CPU.
- `o_req_ready` in→out 2: per-requester accept.
- `i_req_wr` in 2: 1 = write, 0 = read.
- `i_req_addr` in 2×32: bits [31:28] select the layer; bits [27:0] are the rule address.
- `i_req_wdata` in 2×32: write data.
- `o_resp_valid` out 2: one-cycle response pulse to the originating requester.
- `o_resp_rdata` out 32: read data. 0 for writes and errors.
- `o_resp_err` out 1: error flag, qualified by `o_resp_valid`.
- `o_rule_wren` out LAYER_NUM: per-layer write strobe.
- `o_rule_rden` out LAYER_NUM: per-layer read strobe.
- `o_rule_addr` out 32: `{4'b0, addr[27:0]}`, shared by all layers.
- `o_rule_wdata` out 32: shared write data.
- `i_rule_rdata_valid` in LAYER_NUM: per-layer read-data valid.
- `i_rule_rdata` in LAYER_NUM×32: per-layer read data.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- **IDLE**
  - Compute the grant from `i_req_valid` and the round-robin pointer `rr_ptr`. `rr_ptr` names the preferred requester; the other requester is served only if the preferred one is not valid.
  - Assert `o_req_ready[g]` combinationally for the granted requester only. Assert nothing when no request is valid.
  - On handshake, register g, wr, addr and wdata, and set `layer = addr[31:28]`.
  - If `layer >= LAYER_NUM`, go to RESP with err=1. Otherwise go to ISSUE.
- **ISSUE**
  - Drive a one-cycle `o_rule_wren[layer]` (write) or `o_rule_rden[layer]` (read) pulse, with `o_rule_addr` and `o_rule_wdata` valid in the same cycle.
  - Write: go to RESP with err=0.
  - Read: sample `i_rule_rdata_valid[layer]` in this same cycle, because layers may answer combinationally. If it is high, capture `i_rule_rdata[layer]` and go to RESP; otherwise go to WAIT_RD with the wait counter cleared.
- **WAIT_RD**
  - Each cycle: if `i_rule_rdata_valid[layer]`, capture the data and go to RESP.
  - Else if the counter equals TIMEOUT-1, go to RESP with err=1 and rdata=0.
  - Else increment the counter (8-bit, saturating, never wraps).
- **RESP**
  - Pulse `o_resp_valid[g]` for one cycle with registered `o_resp_rdata` and `o_resp_err`.
  - Set `rr_ptr = ~g`, then go to IDLE.
- Only one request is outstanding at a time; `o_req_ready` is 0 outside IDLE.
- `i_rule_rdata_valid` from non-target layers, and from any layer outside ISSUE/WAIT_RD, is ignored.
- `o_rule_addr` and `o_rule_wdata` hold their last registered value; they are meaningful only alongside a strobe.
- Reset mid-operation: the in-flight request is dropped with no response, no strobe is issued after reset, and `rr_ptr` returns to 0.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr` 0, counter 0.
- Write, handshake at cycle T: strobe at T+1, `o_resp_valid` at T+2, back in IDLE at T+3. The next handshake is possible at T+3.
- Read answered during ISSUE: response at T+2.
- Read answered k cycles after ISSUE (1 ≤ k ≤ TIMEOUT-1): response at T+2+k.
- Read timeout: error response at T+1+TIMEOUT+1.
- Out-of-range layer: no strobe, error response at T+1.
- Both requesters valid in IDLE: `rr_ptr` decides, and the loser is served in the very next IDLE.
- A valid request held high during RESP is accepted in the following IDLE cycle.
- All outputs except `o_req_ready` are registered.

## Test plan
- Reset, then host writes addr 0x2000_0010 with data 0xA5A5_0001 -> `o_rule_wren` = 4'b0100, `o_rule_addr` = 0x0000_0010 one cycle after handshake; `o_resp_valid[0]` two cycles after, err=0, rdata=0.
- CPU reads addr 0x1000_0004; layer 1 returns `rdata_valid` in ISSUE with 0x1234_5678 -> `o_resp_valid[1]` at T+2 with rdata 0x1234_5678, err=0. Repeat with a 3-cycle-late answer -> response at T+5.
- Read to layer 3 that never answers, TIMEOUT=15 -> exactly one `rden[3]` pulse; error response at T+17 with rdata 0; no further strobes.
- Both requesters continuously valid with writes -> grants alternate 0,1,0,1 every 3 cycles; each response goes only to the originator.
- Request to addr 0x5000_0000 with LAYER_NUM=4 -> no strobe; err=1 at T+1. Reset asserted during WAIT_RD -> all outputs 0 next cycle, no response, next grant goes to requester 0.
